game_state_fsm: RTL

//  Top-level match sequencer for pong. Consumes player1/player2 scores from score_controller,

---
 rtl/game_state_fsm.sv | 135 +++++++++++++
 1 files changed

// File: rtl/game_state_fsm.sv
// Pong match sequencer: MENU_START -> SERVE -> PLAY -> GAME_OVER, with point/win detection.
// Optional `GAME_OVER_TIMEOUT_EN: GAME_OVER returns to MENU_START after OVER_TICKS ticks.
module game_state_fsm #(
    parameter logic [3:0] WIN_SCORE   = 4'd9,
    parameter int         SERVE_TICKS = 120,
    parameter int         OVER_TICKS  = 600
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       timing_tick,
    input  logic       start_btn,
    input  logic [3:0] player1_score,
    input  logic [3:0] player2_score,
    output logic [1:0] state,
    output logic [1:0] winner,
    output logic       ball_reset,
    output logic       serve_left
);
    typedef enum logic [1:0] {
        MENU_START = 2'd0,
        SERVE      = 2'd1,
        PLAY       = 2'd2,
        GAME_OVER  = 2'd3
    } state_t;

    // A zero tick count behaves like one tick.
    localparam logic [15:0] SERVE_LAST = (SERVE_TICKS <= 1) ? 16'd0 : 16'(SERVE_TICKS - 1);
    localparam logic [15:0] OVER_LAST  = (OVER_TICKS <= 1)  ? 16'd0 : 16'(OVER_TICKS - 1);

    state_t      state_q;
    logic [1:0]  winner_q;
    logic        ball_reset_q;
    logic        serve_left_q;
    logic [15:0] cnt_q;
    logic        start_q;
    logic [3:0]  p1_prev_q;
    logic [3:0]  p2_prev_q;
    logic        p1_pt_q;
    logic        p2_pt_q;

    logic start_press_d;
    logic p1_win_d;
    logic p2_win_d;

    assign start_press_d = start_btn & ~start_q;
    // Prev registers already hold the score that produced the registered point flag.
    assign p1_win_d = (p1_prev_q >= WIN_SCORE);
    assign p2_win_d = (p2_prev_q >= WIN_SCORE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= MENU_START;
            winner_q     <= 2'b00;
            ball_reset_q <= 1'b0;
            serve_left_q <= 1'b0;
            cnt_q        <= 16'd0;
            start_q      <= 1'b0;
            p1_prev_q    <= 4'd0;
            p2_prev_q    <= 4'd0;
            p1_pt_q      <= 1'b0;
            p2_pt_q      <= 1'b0;
        end else begin
            start_q      <= start_btn;
            p1_prev_q    <= player1_score;
            p2_prev_q    <= player2_score;
            p1_pt_q      <= (player1_score > p1_prev_q);
            p2_pt_q      <= (player2_score > p2_prev_q);
            ball_reset_q <= 1'b0;

            case (state_q)
                MENU_START: begin
                    winner_q <= 2'b00;
                    if (start_press_d) begin
                        state_q      <= SERVE;
                        ball_reset_q <= 1'b1;
                        serve_left_q <= 1'b0;
                        cnt_q        <= 16'd0;
                    end
                end
                SERVE: begin
                    if (timing_tick) begin
                        if (cnt_q == SERVE_LAST) begin
                            state_q <= PLAY;
                        end else if (cnt_q != 16'hFFFF) begin
                            cnt_q <= cnt_q + 16'd1;
                        end
                    end
                end
                PLAY: begin
                    if (p1_pt_q || p2_pt_q) begin
                        cnt_q <= 16'd0;
                        if (p1_win_d || p2_win_d) begin
                            state_q  <= GAME_OVER;
                            winner_q <= {p2_win_d, p1_win_d};
                        end else begin
                            state_q      <= SERVE;
                            ball_reset_q <= 1'b1;
                            if (p1_pt_q && !p2_pt_q) begin
                                serve_left_q <= 1'b1;
                            end else if (p2_pt_q && !p1_pt_q) begin
                                serve_left_q <= 1'b0;
                            end
                        end
                    end
                end
                GAME_OVER: begin
                    if (start_press_d) begin
                        state_q  <= MENU_START;
                        winner_q <= 2'b00;
                    end else if (timing_tick) begin
`ifdef GAME_OVER_TIMEOUT_EN
                        if (cnt_q == OVER_LAST) begin
                            state_q  <= MENU_START;
                            winner_q <= 2'b00;
                        end else begin
                            cnt_q <= cnt_q + 16'd1;
                        end
`else
                        // No timeout exit: the count just saturates at the timeout value.
                        if (cnt_q != OVER_LAST) begin
                            cnt_q <= cnt_q + 16'd1;
                        end
`endif
                    end
                end
                default: state_q <= MENU_START;
            endcase
        end
    end

    assign state      = state_q;
    assign winner     = winner_q;
    assign ball_reset = ball_reset_q;
    assign serve_left = serve_left_q;
endmodule
